// File: rtl/nanorv32_gpio_port_if.sv
// rtl/nanorv32_gpio_port_if.sv - nanorv32 data-port bundle between CPU and GPIO responder
//
// Ports (signals of the bundle):
//   sel, req     access qualifier and request, held by the master until early_ready
//   addr         word address, register index in addr[2:0]
//   wdata        write data
//   bytesel      byte write strobes, 0000 = read
//   rdata        read data, nonzero only during ready_r
//   early_ready  access completes at this clock edge
//   ready_r      registered early_ready (response cycle)
interface nanorv32_gpio_port_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  sel;
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic [3:0]            bytesel;
   logic [31:0]           rdata;
   logic                  early_ready;
   logic                  ready_r;

   modport master (
      output sel, req, addr, wdata, bytesel,
      input  rdata, early_ready, ready_r
   );

   modport slave (
      input  sel, req, addr, wdata, bytesel,
      output rdata, early_ready, ready_r
   );
endinterface

// File: rtl/nanorv32_gpio_port.sv
// rtl/nanorv32_gpio_port.sv - memory-mapped GPIO responder for two 16-bit ports
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   bus             nanorv32 data-port slave (sel/req/addr/wdata/bytesel in,
//                   rdata/early_ready/ready_r out)
//   p0_in, p1_in    raw asynchronous pad inputs
//   p0_out, p1_out  output data registers
//   p0_oe, p1_oe    per-bit output enables, 1 = drive
//   irq             registered level interrupt, |(EDGE_STAT & EDGE_MASK)
module nanorv32_gpio_port #(
   parameter int ADDR_WIDTH  = 3,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   nanorv32_gpio_port_if.slave  bus,
   input  logic [15:0]          p0_in,
   input  logic [15:0]          p1_in,
   output logic [15:0]          p0_out,
   output logic [15:0]          p0_oe,
   output logic [15:0]          p1_out,
   output logic [15:0]          p1_oe,
   output logic                 irq
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  cap_addr_q, cap_addr_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]  cap_be_q, cap_be_d;

   logic [31:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [15:0] p0_out_q, p0_out_d, p0_oe_q, p0_oe_d;
   logic [15:0] p1_out_q, p1_out_d, p1_oe_q, p1_oe_d;
   logic [31:0] edge_stat_q, edge_stat_d;
   logic [31:0] edge_mask_q, edge_mask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_r_q, ready_r_d;
   logic        irq_q, irq_d;

   logic        early_ready;
   logic [2:0]  acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_be;
   logic        acc_wr;
   logic        acc_rd;
   logic [31:0] be_mask;
   logic [31:0] rd_mux;
   logic [31:0] rise;
   logic [31:0] stat_clr;

   // Handshake FSM. The access target is the live bus with no wait states,
   // otherwise the values captured when the request was accepted.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
      cap_be_d    = cap_be_q;
      early_ready = 1'b0;
      acc_addr    = cap_addr_q;
      acc_wdata   = cap_wdata_q;
      acc_be      = cap_be_q;
      // A request seen while rst is high is discarded, never acknowledged.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (bus.sel && bus.req) begin
                  cap_addr_d  = bus.addr[2:0];
                  cap_wdata_d = bus.wdata;
                  cap_be_d    = bus.bytesel;
                  if (WAIT_STATES == 0) begin
                     early_ready = 1'b1;
                     acc_addr    = bus.addr[2:0];
                     acc_wdata   = bus.wdata;
                     acc_be      = bus.bytesel;
                  end else begin
                     cnt_d   = WAIT_LOAD;
                     state_d = WAIT;
                  end
               end
            end
            // req is not looked at here: a dropped request still completes.
            WAIT: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  early_ready = 1'b1;
                  state_d     = DONE;
               end
            end
            // One dead cycle so a req still held after early_ready is not
            // taken as a second access.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign acc_wr  = early_ready && (acc_be != 4'd0);
   assign acc_rd  = early_ready && (acc_be == 4'd0);
   assign be_mask = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};

   always_comb begin
      rd_mux = 32'd0;
      case (acc_addr)
         3'd0: rd_mux = {16'd0, p0_out_q};
         3'd1: rd_mux = {16'd0, p0_oe_q};
         3'd2: rd_mux = {16'd0, s2_q[15:0]};
         3'd3: rd_mux = {16'd0, p1_out_q};
         3'd4: rd_mux = {16'd0, p1_oe_q};
         3'd5: rd_mux = {16'd0, s2_q[31:16]};
         3'd6: rd_mux = edge_stat_q;
         3'd7: rd_mux = edge_mask_q;
         default: rd_mux = 32'd0;
      endcase
   end

   // Input path: s1/s2 synchronize, s3 holds the previous synchronized value.
   assign rise     = s2_q & ~s3_q;
   assign stat_clr = (acc_wr && acc_addr == 3'd6) ? (acc_wdata & be_mask) : 32'd0;

   always_comb begin
      s1_d      = {p1_in, p0_in};
      s2_d      = s1_q;
      s3_d      = s2_q;
      p0_out_d  = p0_out_q;
      p0_oe_d   = p0_oe_q;
      p1_out_d  = p1_out_q;
      p1_oe_d   = p1_oe_q;
      edge_mask_d = edge_mask_q;
      // Set wins over a simultaneous write-one-to-clear.
      edge_stat_d = (edge_stat_q & ~stat_clr) | rise;
      if (acc_wr) begin
         case (acc_addr)
            3'd0: p0_out_d = (p0_out_q & ~be_mask[15:0]) | (acc_wdata[15:0] & be_mask[15:0]);
            3'd1: p0_oe_d  = (p0_oe_q  & ~be_mask[15:0]) | (acc_wdata[15:0] & be_mask[15:0]);
            3'd3: p1_out_d = (p1_out_q & ~be_mask[15:0]) | (acc_wdata[15:0] & be_mask[15:0]);
            3'd4: p1_oe_d  = (p1_oe_q  & ~be_mask[15:0]) | (acc_wdata[15:0] & be_mask[15:0]);
            3'd7: edge_mask_d = (edge_mask_q & ~be_mask) | (acc_wdata & be_mask);
            default: ;
         endcase
      end
      rdata_d   = acc_rd ? rd_mux : 32'd0;
      ready_r_d = early_ready;
      irq_d     = |(edge_stat_q & edge_mask_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         cap_addr_q  <= 3'd0;
         cap_wdata_q <= 32'd0;
         cap_be_q    <= 4'd0;
         s1_q        <= 32'd0;
         s2_q        <= 32'd0;
         s3_q        <= 32'd0;
         p0_out_q    <= 16'd0;
         p0_oe_q     <= 16'd0;
         p1_out_q    <= 16'd0;
         p1_oe_q     <= 16'd0;
         edge_stat_q <= 32'd0;
         edge_mask_q <= 32'd0;
         rdata_q     <= 32'd0;
         ready_r_q   <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_addr_q  <= cap_addr_d;
         cap_wdata_q <= cap_wdata_d;
         cap_be_q    <= cap_be_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         p0_out_q    <= p0_out_d;
         p0_oe_q     <= p0_oe_d;
         p1_out_q    <= p1_out_d;
         p1_oe_q     <= p1_oe_d;
         edge_stat_q <= edge_stat_d;
         edge_mask_q <= edge_mask_d;
         rdata_q     <= rdata_d;
         ready_r_q   <= ready_r_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.early_ready = early_ready;
   assign bus.ready_r     = ready_r_q;
   assign bus.rdata       = rdata_q;
   assign p0_out = p0_out_q;
   assign p0_oe  = p0_oe_q;
   assign p1_out = p1_out_q;
   assign p1_oe  = p1_oe_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_nanorv32_gpio_port.sv
// tb/tb_nanorv32_gpio_port.sv - scoreboard bench for nanorv32_gpio_port (0 and 3 wait states)
module tb_nanorv32_gpio_port;

   logic clk;
   logic rst;
   logic [15:0] p0_in0, p1_in0, p0_out0, p0_oe0, p1_out0, p1_oe0;
   logic [15:0] p0_in1, p1_in1, p0_out1, p0_oe1, p1_out1, p1_oe1;
   logic irq0, irq1;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   nanorv32_gpio_port_if #(.ADDR_WIDTH(3)) bus0();
   nanorv32_gpio_port_if #(.ADDR_WIDTH(3)) bus1();

   nanorv32_gpio_port #(.ADDR_WIDTH(3), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .p0_in(p0_in0), .p1_in(p1_in0),
      .p0_out(p0_out0), .p0_oe(p0_oe0), .p1_out(p1_out0), .p1_oe(p1_oe0),
      .irq(irq0)
   );

   nanorv32_gpio_port #(.ADDR_WIDTH(3), .WAIT_STATES(3)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .p0_in(p0_in1), .p1_in(p1_in1),
      .p0_out(p0_out1), .p0_oe(p0_oe1), .p1_out(p1_out1), .p1_oe(p1_oe1),
      .irq(irq1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every ready_r pops one expected rdata.
   always @(negedge clk) begin
      if (bus0.ready_r === 1'b1) begin
         if (q0.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL rd0_unexpected: ready_r=1 with no access pending, expected 0 at %0t", $time);
         end else begin
            chk("rdata0", bus0.rdata, q0.pop_front());
         end
      end
      if (bus1.ready_r === 1'b1) begin
         if (q1.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL rd1_unexpected: ready_r=1 with no access pending, expected 0 at %0t", $time);
         end else begin
            chk("rdata1", bus1.rdata, q1.pop_front());
         end
      end
   end

   // Called just after a rising edge; returns just after the access edge.
   task automatic acc0(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp);
      bus0.sel = 1'b1; bus0.req = 1'b1; bus0.addr = a; bus0.wdata = d; bus0.bytesel = be;
      q0.push_back(exp);
      @(negedge clk);
      chk("early_ready0", 32'(bus0.early_ready), 32'd1);
      @(posedge clk);
      #1;
      bus0.sel = 1'b0; bus0.req = 1'b0;
   endtask

   // Request stays held through DONE; caller either issues the next one or drops req.
   task automatic acc1(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp);
      int n;
      bus1.sel = 1'b1; bus1.req = 1'b1; bus1.addr = a; bus1.wdata = d; bus1.bytesel = be;
      q1.push_back(exp);
      n = 0;
      @(negedge clk);
      while (bus1.early_ready !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("latency1", 32'(n), 32'd3);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_early_ready1", 32'(bus1.early_ready), 32'd0);
      chk("done_ready_r1", 32'(bus1.ready_r), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus0.sel = 1'b0; bus0.req = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.bytesel = '0;
      bus1.sel = 1'b0; bus1.req = 1'b0; bus1.addr = '0; bus1.wdata = '0; bus1.bytesel = '0;
      p0_in0 = '0; p1_in0 = '0; p0_in1 = '0; p1_in1 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_p0_out", 32'(p0_out0), 32'd0);
      chk("rst_p0_oe", 32'(p0_oe0), 32'd0);
      chk("rst_p1_out", 32'(p1_out0), 32'd0);
      chk("rst_p1_oe", 32'(p1_oe0), 32'd0);
      chk("rst_irq", 32'(irq0), 32'd0);
      chk("rst_early_ready", 32'(bus0.early_ready), 32'd0);
      chk("rst_ready_r", 32'(bus0.ready_r), 32'd0);
      chk("rst_rdata", bus0.rdata, 32'd0);
      to_next();

      // Read all registers; ready_r one cycle after early_ready
      acc0(3'd0, 32'd0, 4'b0000, 32'd0);
      @(negedge clk);
      chk("ready_r_after", 32'(bus0.ready_r), 32'd1);
      to_next();
      for (int a = 1; a < 8; a++) acc0(3'(a), 32'd0, 4'b0000, 32'd0);

      // Writes, byte strobes, ignored upper strobes and ro registers
      acc0(3'd1, 32'h000000FF, 4'b1111, 32'd0);
      acc0(3'd0, 32'h00001234, 4'b1111, 32'd0);
      @(negedge clk);
      chk("p0_oe_pin", 32'(p0_oe0), 32'h000000FF);
      chk("p0_out_pin", 32'(p0_out0), 32'h00001234);
      to_next();
      acc0(3'd0, 32'h0000AB00, 4'b0010, 32'd0);
      @(negedge clk);
      chk("p0_out_byte1", 32'(p0_out0), 32'h0000AB34);
      to_next();
      acc0(3'd3, 32'hFFFFFFFF, 4'b1100, 32'd0);
      acc0(3'd3, 32'd0, 4'b0000, 32'd0);
      acc0(3'd2, 32'h0000FFFF, 4'b1111, 32'd0);
      acc0(3'd2, 32'd0, 4'b0000, 32'd0);
      acc0(3'd1, 32'd0, 4'b0000, 32'h000000FF);
      acc0(3'd0, 32'd0, 4'b0000, 32'h0000AB34);

      // Input sync, edge capture and irq
      acc0(3'd7, 32'h00010000, 4'b1111, 32'd0);
      p1_in0 = 16'h8001;
      repeat (2) @(posedge clk);
      #1;
      acc0(3'd5, 32'd0, 4'b0000, 32'h00008001);
      chk("irq_clk3", 32'(irq0), 32'd0);
      acc0(3'd6, 32'd0, 4'b0000, 32'h80010000);
      chk("irq_clk4", 32'(irq0), 32'd1);

      // Clear coinciding with a new rising edge on bit 16: set wins
      p1_in0 = 16'h8000;
      repeat (4) @(posedge clk);
      #1;
      p1_in0 = 16'h8001;
      repeat (2) @(posedge clk);
      #1;
      acc0(3'd6, 32'h00010000, 4'b0100, 32'd0);
      acc0(3'd6, 32'd0, 4'b0000, 32'h80010000);
      acc0(3'd6, 32'h00010000, 4'b0100, 32'd0);
      chk("irq_before_fall", 32'(irq0), 32'd1);
      acc0(3'd6, 32'd0, 4'b0000, 32'h80000000);
      chk("irq_fall", 32'(irq0), 32'd0);
      acc0(3'd6, 32'hFFFFFFFF, 4'b0111, 32'd0);
      acc0(3'd6, 32'd0, 4'b0000, 32'h80000000);
      acc0(3'd6, 32'h80000000, 4'b1000, 32'd0);
      acc0(3'd6, 32'd0, 4'b0000, 32'd0);
      acc0(3'd7, 32'd0, 4'b0000, 32'h00010000);

      // Three wait states, req held across DONE
      acc1(3'd0, 32'h00005A5A, 4'b0011, 32'd0);
      acc1(3'd0, 32'd0, 4'b0000, 32'h00005A5A);
      bus1.sel = 1'b0; bus1.req = 1'b0;
      @(negedge clk);
      chk("p0_out1_pin", 32'(p0_out1), 32'h00005A5A);
      to_next();

      // Reset during WAIT discards the access
      bus1.sel = 1'b1; bus1.req = 1'b1; bus1.addr = 3'd1; bus1.wdata = 32'h0000FFFF; bus1.bytesel = 4'b0011;
      to_next();
      rst = 1'b1;
      bus1.sel = 1'b0; bus1.req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("rst_wait_early_ready1", 32'(bus1.early_ready), 32'd0);
         chk("rst_wait_ready_r1", 32'(bus1.ready_r), 32'd0);
      end
      chk("rst_wait_p0_oe1", 32'(p0_oe1), 32'd0);
      chk("rst_wait_p0_out1", 32'(p0_out1), 32'd0);
      to_next();
      acc1(3'd1, 32'd0, 4'b0000, 32'd0);
      bus1.sel = 1'b0; bus1.req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
